// File: rtl/lc3_trace_buffer_if.sv
// Control, probe and readout bundle of the LC3 trace buffer.
// The master side drives arm/mode/probes/read index; the slave side
// is the recorder itself.
interface lc3_trace_buffer_if #(
    parameter int unsigned SNAP_W = 192,
    parameter int unsigned DEPTH  = 16
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = IDX_W + 1;

    logic              arm;
    logic [1:0]        mode;
    logic [5:0]        trigger_state;
    logic [5:0]        debugCurrentState;
    logic [5:0]        debugNextState;
    logic [SNAP_W-1:0] snap;
    logic [IDX_W-1:0]  rd_idx;
    logic [SNAP_W-1:0] rd_data;
    logic [CNT_W-1:0]  count;
    logic              capturing;
    logic              triggered;
    logic              wrapped;
    logic              done;

    modport master (
        output arm, mode, trigger_state, debugCurrentState, debugNextState, snap, rd_idx,
        input  rd_data, count, capturing, triggered, wrapped, done
    );

    modport slave (
        input  arm, mode, trigger_state, debugCurrentState, debugNextState, snap, rd_idx,
        output rd_data, count, capturing, triggered, wrapped, done
    );
endinterface

// File: rtl/lc3_trace_buffer.sv
// Execution-trace recorder for the LC3 core: snapshots one state word per
// FETCH into a circular buffer with wrap, stop-when-full and triggered
// post-capture modes, plus registered random-access readout.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | after reset; nothing recorded until arm
// CAPTURE | recording every FETCH; mode 2 watches for the trigger here
// POST    | trigger seen; recording POST_SAMPLES more FETCHes
// DONE    | capture finished; buffer and count frozen until arm/reset
module lc3_trace_buffer #(
    parameter int unsigned SNAP_W       = 192,
    parameter int unsigned DEPTH        = 16,
    parameter logic [5:0]  FETCH_STATE  = 6'd18,
    parameter int unsigned POST_SAMPLES = 4
) (
    input logic               clk,
    input logic               reset_n,
    lc3_trace_buffer_if.slave bus
);
    localparam int unsigned     IDX_W     = $clog2(DEPTH);
    localparam int unsigned     CNT_W     = IDX_W + 1;
    localparam logic [CNT_W-1:0] FULL      = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] LAST      = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] POST_INIT = CNT_W'(POST_SAMPLES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        POST    = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        mode_q;
    logic [IDX_W-1:0]  wr_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  post_cnt_q, post_cnt_d;
    logic              triggered_q, triggered_d;
    logic              wrapped_q;
    logic [SNAP_W-1:0] mem [DEPTH];
    logic [SNAP_W-1:0] rd_data_q;
    logic              sample;
    logic              trig_hit;
    logic [IDX_W-1:0]  rd_base;
    logic [IDX_W-1:0]  rd_addr;

    assign sample   = ((state_q == CAPTURE) || (state_q == POST)) &&
                      (bus.debugNextState == FETCH_STATE);
    assign trig_hit = (state_q == CAPTURE) && (mode_q == 2'd2) &&
                      (bus.debugCurrentState == bus.trigger_state);

    // Next-state logic; arm overrides every other event in the cycle.
    always_comb begin
        state_d     = state_q;
        post_cnt_d  = post_cnt_q;
        triggered_d = triggered_q;
        if (bus.arm) begin
            state_d     = CAPTURE;
            post_cnt_d  = '0;
            triggered_d = 1'b0;
        end else begin
            case (state_q)
                CAPTURE: begin
                    if (trig_hit) begin
                        state_d     = POST;
                        post_cnt_d  = POST_INIT;
                        triggered_d = 1'b1;
                    end else if ((mode_q == 2'd1) && sample && (count_q == LAST)) begin
                        state_d = DONE;
                    end
                end
                POST: begin
                    if (sample) begin
                        post_cnt_d = post_cnt_q - CNT_W'(1);
                        if (post_cnt_q == CNT_W'(1)) begin
                            state_d = DONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // FSM register, trigger bookkeeping and mode latch (mode only sampled on arm).
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            post_cnt_q  <= '0;
            triggered_q <= 1'b0;
            mode_q      <= 2'd0;
        end else begin
            state_q     <= state_d;
            post_cnt_q  <= post_cnt_d;
            triggered_q <= triggered_d;
            if (bus.arm) begin
                mode_q <= bus.mode;
            end
        end
    end

    // Write pointer, saturating fill count and overwrite flag.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q  <= '0;
            count_q   <= '0;
            wrapped_q <= 1'b0;
        end else if (bus.arm) begin
            wr_ptr_q  <= '0;
            count_q   <= '0;
            wrapped_q <= 1'b0;
        end else if (sample) begin
            wr_ptr_q <= wr_ptr_q + IDX_W'(1);
            if (count_q == FULL) begin
                wrapped_q <= 1'b1;
            end else begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    // Snapshot storage; no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (reset_n && !bus.arm && sample) begin
            mem[wr_ptr_q] <= bus.snap;
        end
    end

    // Once full, the oldest entry sits at wr_ptr; before that it is slot 0.
    assign rd_base = (count_q == FULL) ? wr_ptr_q : '0;
    assign rd_addr = rd_base + bus.rd_idx;

    // Registered readout; indices beyond the fill level read as zero.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_data_q <= '0;
        end else if ({1'b0, bus.rd_idx} < count_q) begin
            rd_data_q <= mem[rd_addr];
        end else begin
            rd_data_q <= '0;
        end
    end

    assign bus.rd_data   = rd_data_q;
    assign bus.count     = count_q;
    assign bus.capturing = (state_q == CAPTURE) || (state_q == POST);
    assign bus.triggered = triggered_q;
    assign bus.wrapped   = wrapped_q;
    assign bus.done      = (state_q == DONE);
endmodule
